// File: rtl/avg_pkg.sv
// avg_pkg: sample width and feeder state type shared by average, its feeder and their benches
package avg_pkg;
  localparam int W_SAMPLE = 4;
  typedef enum logic [1:0] {IDLE, ARMED, LOAD, DONE} feeder_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: circular-buffer FIFO with registered read data and an occupancy count
module sample_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // dout only changes on a pop, so it doubles as the held output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dout <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout <= mem[rd_ptr];
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/avg_sample_feeder.sv
// avg_sample_feeder: buffers samples and replays N-sample batches into average on start
module avg_sample_feeder
  import avg_pkg::*;
#(
  parameter int W = W_SAMPLE,
  parameter int DEPTH = 8,
  parameter int N = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [W-1:0]                 in_data,
  output logic                         in_ready,
  input  logic                         start,
  output logic [W-1:0]                 x,
  output logic                         x_load,
  output logic                         done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  feeder_state_t state, nxt;
  logic [CW-1:0] bcnt;
  logic full, empty, pop, enough;
  assign in_ready = !full;
  assign enough = count >= CW'(N);
  sample_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid), .pop(pop), .din(in_data),
    .dout(x), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (enough ? LOAD : ARMED) : IDLE;
      ARMED:   nxt = enough ? LOAD : ARMED;
      LOAD:    nxt = bcnt == CW'(N-1) ? DONE : LOAD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    pop = state == LOAD && !empty;
  end
  // x_load and done lag the state by one edge to line up with the registered x
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcnt <= '0;
      x_load <= 1'b0;
      done <= 1'b0;
    end else begin
      bcnt <= state == LOAD ? bcnt + CW'(1) : '0;
      x_load <= state == LOAD;
      done <= state == DONE;
    end
endmodule

// File: tb/tb_avg_sample_feeder.sv
// tb_avg_sample_feeder: directed and random stimulus checked against a queue-based timeline model
module tb_avg_sample_feeder;
  import avg_pkg::*;
  localparam int W = W_SAMPLE;
  localparam int DEPTH = 8;
  localparam int N = 4;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 0, rst = 1, in_valid = 0, start = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, x_load, done, busy;
  logic [W-1:0] x;
  logic [CW-1:0] count;
  avg_sample_feeder #(.W(W), .DEPTH(DEPTH), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .x(x), .x_load(x_load), .done(done), .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_x;
  bit exp_xl, exp_done, mbusy, armed;
  int pop_left, done_at, ecount;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    exp_x = '0;
    exp_xl = 0;
    exp_done = 0;
    mbusy = 0;
    armed = 0;
    pop_left = 0;
    done_at = -1;
  endtask
  // pops land one edge after a batch is triggered; done follows the last pop by one edge
  task automatic model_edge();
    int sz = q.size();
    bit b = mbusy, a = armed;
    ecount++;
    exp_xl = 0;
    exp_done = ecount == done_at;
    if (pop_left > 0) begin
      exp_x = q.pop_front();
      exp_xl = 1;
      pop_left--;
      if (pop_left == 0) done_at = ecount + 1;
    end
    if (in_valid && sz < DEPTH) q.push_back(in_data);
    if (!b && start) begin
      mbusy = 1;
      if (sz >= N) pop_left = N;
      else armed = 1;
    end else if (a && sz >= N) begin
      armed = 0;
      pop_left = N;
    end
    if (ecount == done_at) mbusy = 0;
  endtask
  task automatic check_all();
    chk("x", x, exp_x);
    chk("x_load", x_load, exp_xl);
    chk("done", done, exp_done);
    chk("busy", busy, mbusy);
    chk("count", count, q.size());
    chk("in_ready", in_ready, q.size() < DEPTH);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic push(input logic [W-1:0] v);
    in_valid = 1;
    in_data = v;
    step();
    in_valid = 0;
  endtask
  task automatic batch(input int tail);
    start = 1;
    step();
    start = 0;
    run(tail);
  endtask
  initial begin
    model_reset();
    ecount = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 0;
    push(5); push(3); push(7); push(1);
    batch(N + 3);
    push(2); push(4);
    batch(2);
    push(6); push(9);
    run(N + 4);
    for (int i = 0; i < DEPTH + 1; i++) push(W'(i + 1));
    run(1);
    batch(N + 3);
    for (int i = 0; i < 4; i++) push(W'($urandom));
    start = 1;
    in_valid = 1;
    for (int i = 0; i < N + 5; i++) begin
      in_data = W'($urandom);
      step();
      start = 0;
    end
    in_valid = 0;
    batch(N + 3);
    batch(N + 3);
    for (int i = 0; i < 4; i++) push(W'($urandom));
    start = 1;
    run(N + 2);
    start = 0;
    run(4);
    for (int i = 0; i < 4; i++) push(W'($urandom));
    batch(2);
    #1 rst = 1;
    #1;
    chk("rst_x", x, 0);
    chk("rst_x_load", x_load, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    model_reset();
    #1 rst = 0;
    run(N + 4);
    repeat (400) begin
      in_valid = $urandom_range(0, 99) < 60;
      in_data = W'($urandom);
      start = $urandom_range(0, 9) == 0;
      step();
    end
    in_valid = 0;
    start = 0;
    run(12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
